// File: rtl/frame_draw_sequencer.sv
// Per-frame draw sequencer: background redraw, then lander sprite, then idle until frameTick.
// Pixel path: 1-cycle registered pipeline, aligned with the 1-cycle background ROM read.
// No backpressure: the VGA stream is fire-and-forget; extra frame ticks while drawing are dropped.
module frame_draw_sequencer #(
  parameter logic [2:0] TRANSPARENT = 3'b000,
  parameter logic [2:0] MAX_LEVEL   = 3'd4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       frameTick,
  input  logic       levelReq,
  input  logic [2:0] nextLevel,
  input  logic       backgroundDone,
  input  logic [7:0] backgroundX,
  input  logic [6:0] backgroundY,
  input  logic [2:0] backgroundColour,
  input  logic       spriteDone,
  input  logic [7:0] spriteX,
  input  logic [6:0] spriteY,
  input  logic [2:0] spriteColour,
  output logic       backgroundSignal,
  output logic       plotSignal,
  output logic       spriteSignal,
  output logic [2:0] currentLevel,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColour,
  output logic       writeEn,
  output logic       frameBusy
);

  localparam logic [2:0] S_START        = 3'd0;
  localparam logic [2:0] S_BG           = 3'd1;
  localparam logic [2:0] S_BG_FLUSH     = 3'd2;
  localparam logic [2:0] S_SPRITE       = 3'd3;
  localparam logic [2:0] S_SPRITE_FLUSH = 3'd4;
  localparam logic [2:0] S_WAIT         = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic       pend_vld;
  logic [2:0] pend_lvl;
  logic       level_ok;
  logic       frame_start;

  logic [7:0] p_x;
  logic [6:0] p_y;
  logic       p_vld;
  logic       p_src_sprite;
  logic [2:0] p_col;
  logic [2:0] src_colour;
  logic       sprite_phase;

  assign level_ok     = levelReq && (nextLevel <= MAX_LEVEL);
  assign frame_start  = (state == S_WAIT) && frameTick;
  assign sprite_phase = (state == S_SPRITE);

  // Next-state: phases advance on drawer done flags; frameTick only counts in S_WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_START:        state_nxt = S_BG;
      S_BG:           if (backgroundDone) state_nxt = S_BG_FLUSH;
      S_BG_FLUSH:     state_nxt = S_SPRITE;
      S_SPRITE:       if (spriteDone) state_nxt = S_SPRITE_FLUSH;
      S_SPRITE_FLUSH: state_nxt = S_WAIT;
      S_WAIT:         if (frameTick) state_nxt = S_BG;
      default:        state_nxt = S_START;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_START;
    else         state <= state_nxt;
  end

  // Level requests park in a pending slot and only reach currentLevel at a frame boundary.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pend_vld     <= 1'b0;
      pend_lvl     <= 3'd0;
      currentLevel <= 3'd0;
    end else begin
      if (frame_start && pend_vld) begin
        currentLevel <= pend_lvl;
        pend_vld     <= 1'b0;
      end
      // A request arriving in the same cycle as the apply stays pending for the next frame.
      if (level_ok) begin
        pend_lvl <= nextLevel;
        pend_vld <= 1'b1;
      end
    end
  end

  // Pixel pipeline: register coordinates and qualifiers so they line up with the ROM colour.
  // The background drawer raises done together with its final address, so every S_BG cycle
  // carries a real pixel; the last one lands on the VGA side during S_BG_FLUSH.
  // The sprite drawer raises done one cycle after its final address, so that cycle is dropped.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_x          <= 8'd0;
      p_y          <= 7'd0;
      p_vld        <= 1'b0;
      p_src_sprite <= 1'b0;
      p_col        <= 3'd0;
    end else begin
      p_x          <= sprite_phase ? spriteX : backgroundX;
      p_y          <= sprite_phase ? spriteY : backgroundY;
      p_vld        <= (state == S_BG) || (sprite_phase && !spriteDone);
      p_src_sprite <= sprite_phase;
      p_col        <= spriteColour;
    end
  end

  assign src_colour = p_src_sprite ? p_col : backgroundColour;
  assign writeEn    = p_vld && !(p_src_sprite && (p_col == TRANSPARENT));
  assign vgaColour  = writeEn ? src_colour : 3'd0;
  assign vgaX       = p_x;
  assign vgaY       = p_y;

  assign backgroundSignal = (state == S_BG);
  assign plotSignal       = (state == S_BG) || (state == S_BG_FLUSH);
  assign spriteSignal     = (state == S_SPRITE);
  assign frameBusy        = (state == S_BG) || (state == S_BG_FLUSH) || (state == S_SPRITE);

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: drawer/ROM models feed a scoreboard of expected VGA writes.
// Expected pixels are queued when the models issue them; a negedge monitor pops on writeEn.
// All waits on DUT events are cycle-bounded; a timeout is counted as a failure.
module tb_frame_draw_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       frameTick = 1'b0;
  logic       levelReq = 1'b0;
  logic [2:0] nextLevel = 3'd0;
  logic       backgroundDone;
  logic [7:0] backgroundX;
  logic [6:0] backgroundY;
  logic [2:0] backgroundColour = 3'd0;
  logic       spriteDone;
  logic [7:0] spriteX;
  logic [6:0] spriteY;
  logic [2:0] spriteColour;
  logic       backgroundSignal;
  logic       plotSignal;
  logic       spriteSignal;
  logic [2:0] currentLevel;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       writeEn;
  logic       frameBusy;

  frame_draw_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .frameTick(frameTick), .levelReq(levelReq),
    .nextLevel(nextLevel), .backgroundDone(backgroundDone), .backgroundX(backgroundX),
    .backgroundY(backgroundY), .backgroundColour(backgroundColour), .spriteDone(spriteDone),
    .spriteX(spriteX), .spriteY(spriteY), .spriteColour(spriteColour),
    .backgroundSignal(backgroundSignal), .plotSignal(plotSignal), .spriteSignal(spriteSignal),
    .currentLevel(currentLevel), .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour),
    .writeEn(writeEn), .frameBusy(frameBusy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   writes = 0;

  // Background drawer model: raster counter, done with the final address, cleared by plot low.
  int   bg_w = 160;
  int   bg_h = 120;
  int   bg_cnt;
  // Sprite drawer model: 4x4 at (50,60), even pixels 101, odd transparent, done one cycle late.
  int   sp_cnt;
  logic sp_done;

  assign backgroundX    = 8'(bg_cnt % bg_w);
  assign backgroundY    = 7'(bg_cnt / bg_w);
  assign backgroundDone = (bg_cnt == bg_w * bg_h - 1);
  assign spriteX        = 8'(50 + sp_cnt % 4);
  assign spriteY        = 7'(60 + sp_cnt / 4);
  assign spriteColour   = sp_cnt[0] ? 3'b000 : 3'b101;
  assign spriteDone     = sp_done;

  // ROM with colour = address[2:0], one cycle read latency.
  always @(posedge Clock) backgroundColour <= 3'(bg_cnt);

  // Drawer models; each issued visible pixel becomes an expected VGA write.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bg_cnt  <= 0;
      sp_cnt  <= 0;
      sp_done <= 1'b0;
    end else begin
      if (backgroundSignal && plotSignal)
        exp_q.push_back({backgroundX, backgroundY, 3'(bg_cnt)});
      if (spriteSignal && !sp_done && spriteColour != 3'b000)
        exp_q.push_back({spriteX, spriteY, spriteColour});
      if (!plotSignal) bg_cnt <= 0;
      else if (backgroundSignal && bg_cnt < bg_w * bg_h - 1) bg_cnt <= bg_cnt + 1;
      if (!spriteSignal) begin
        sp_cnt  <= 0;
        sp_done <= 1'b0;
      end else if (sp_cnt < 15) sp_cnt <= sp_cnt + 1;
      else sp_done <= 1'b1;
    end
  end

  // Monitor: every VGA write must match the oldest expected pixel.
  always @(negedge Clock) begin
    if (Resetn && writeEn) begin
      pix_t e;
      writes++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got (%0d,%0d) col %0d, expected no write", vgaX, vgaY, vgaColour);
      end else begin
        e = exp_q.pop_front();
        if ({vgaX, vgaY, vgaColour} != e) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d) col %0d, expected (%0d,%0d) col %0d",
                   vgaX, vgaY, vgaColour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // which: 0 = backgroundDone, 1 = spriteDone. Returns at the negedge where it is seen.
  task automatic wait_for(input string name, input int which, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge Clock);
      hit = (which == 0) ? backgroundDone : spriteDone;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles, expected event", name, budget);
    end
  endtask

  task automatic pulse_level(input logic [2:0] lvl);
    nextLevel = lvl;
    levelReq  = 1'b1;
    @(negedge Clock);
    levelReq  = 1'b0;
  endtask

  task automatic tick_and_check(input string name, input int exp_lvl);
    frameTick = 1'b1;
    @(negedge Clock);
    frameTick = 1'b0;
    chk({name, "_bg_on"}, int'(backgroundSignal), 1);
    chk({name, "_level"}, int'(currentLevel), exp_lvl);
  endtask

  task automatic finish_frame(input string name, input int exp_writes);
    wait_for({name, "_bg_done"}, 0, 20000);
    wait_for({name, "_sp_done"}, 1, 200);
    chk({name, "_busy_at_sp_done"}, int'(frameBusy), 1);
    @(negedge Clock);
    chk({name, "_busy_drop"}, int'(frameBusy), 0);
    repeat (4) @(negedge Clock);
    chk({name, "_writes"}, writes, exp_writes);
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge Clock);
    chk("rst_we", int'(writeEn), 0);
    chk("rst_bg", int'(backgroundSignal), 0);
    chk("rst_plot", int'(plotSignal), 0);
    chk("rst_busy", int'(frameBusy), 0);
    chk("rst_level", int'(currentLevel), 0);

    // Frame 1: full 160x120 screen.
    Resetn = 1'b1;
    #1;
    chk("start_bg_off", int'(backgroundSignal), 0);
    @(negedge Clock);
    chk("bg_entered", int'(backgroundSignal), 1);
    chk("bg_plot", int'(plotSignal), 1);
    chk("bg_busy", int'(frameBusy), 1);
    chk("bg_level0", int'(currentLevel), 0);
    frameTick = 1'b1;
    pulse_level(3'd2);
    frameTick = 1'b0;
    wait_for("f1_bg_done", 0, 20000);
    @(negedge Clock);
    chk("flush_we", int'(writeEn), 1);
    chk("flush_x", int'(vgaX), 159);
    chk("flush_y", int'(vgaY), 119);
    chk("flush_col", int'(vgaColour), 7);
    chk("flush_plot", int'(plotSignal), 1);
    chk("flush_bg_off", int'(backgroundSignal), 0);
    @(negedge Clock);
    chk("sp_plot_low", int'(plotSignal), 0);
    chk("sp_on", int'(spriteSignal), 1);
    pulse_level(3'd3);
    pulse_level(3'd5);
    chk("sp_level0", int'(currentLevel), 0);
    wait_for("f1_sp_done", 1, 200);
    chk("f1_busy_at_sp_done", int'(frameBusy), 1);
    @(negedge Clock);
    chk("f1_busy_drop", int'(frameBusy), 0);
    chk("f1_sp_off", int'(spriteSignal), 0);
    repeat (8) @(negedge Clock);
    chk("f1_writes", writes, 19200 + 8);
    chk("f1_q_empty", exp_q.size(), 0);
    chk("wait_tick_dropped", int'(backgroundSignal), 0);
    chk("wait_level0", int'(currentLevel), 0);

    // Frame 2: pending level 3 applies on the tick; smaller screen keeps the run short.
    bg_w = 16;
    bg_h = 4;
    writes = 0;
    tick_and_check("f2", 3);
    finish_frame("f2", 64 + 8);

    // Frame 3: reset mid-background discards the pending level.
    writes = 0;
    tick_and_check("f3", 3);
    pulse_level(3'd1);
    repeat (20) @(negedge Clock);
    #2;
    Resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_we", int'(writeEn), 0);
    chk("mid_rst_bg", int'(backgroundSignal), 0);
    chk("mid_rst_plot", int'(plotSignal), 0);
    chk("mid_rst_busy", int'(frameBusy), 0);
    chk("mid_rst_level", int'(currentLevel), 0);
    chk("mid_rst_x", int'(vgaX), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    writes = 0;
    @(negedge Clock);
    chk("rerun_bg", int'(backgroundSignal), 1);
    chk("rerun_level", int'(currentLevel), 0);
    finish_frame("f4", 64 + 8);
    tick_and_check("f5", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
